dds_gen_multi: RTL and testbench

Parametrised multi-waveform DDS phase generator with runtime configuration. It is the successor to the fixed-word, two-wave DDS controller.
- Drives an external synchronous waveform ROM laid out as N_WAVE banks of 2^ADDR_W samples, and registers ROM data out to the DAC.
- Adds a config handshake, wrap-coherent parameter updates, a run/hold control and a ping-pong frequency sweep FSM.

---
 rtl/dds_gen_multi.sv | 197 +++++++++++++++++++
 tb/tb_dds_gen_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_gen_multi.sv
// dds_gen_multi: multi-waveform DDS phase generator with a config handshake,
// wrap-coherent parameter updates, run/hold control and a ping-pong
// frequency sweep.
// Optional build macro: AMP_SCALE_EN. When it is defined, the block gains a
// cfg_amp port and the output sample is scaled by (amp+1)/256.
// Pipeline: acc -> phase -> rom_addr -> (external ROM) -> dac_data.
module dds_gen_multi #(
   parameter int ACC_W      = 32,
   parameter int ADDR_W     = 12,
   parameter int N_WAVE     = 4,
   parameter int WSEL_W     = 2,
   parameter int DATA_W     = 8,
   parameter int F_WORD_RST = 42949,
   parameter int P_WORD_RST = 1024
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     run,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [ACC_W-1:0]         cfg_f_word,
   input  logic [ADDR_W-1:0]        cfg_p_word,
   input  logic [WSEL_W-1:0]        cfg_wave_sel,
`ifdef AMP_SCALE_EN
   input  logic [7:0]               cfg_amp,
`endif
   input  logic                     sweep_en,
   input  logic [ACC_W-1:0]         sweep_step,
   input  logic [ACC_W-1:0]         sweep_f_max,
   output logic [WSEL_W+ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]        rom_q,
   output logic [DATA_W-1:0]        dac_data,
   output logic                     dac_valid,
   output logic                     wrap,
   output logic [1:0]               state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_UP   = 2'b10,
      S_DOWN = 2'b11
   } state_t;

   localparam logic [ACC_W-1:0]  F_RST = ACC_W'(F_WORD_RST);
   localparam logic [ADDR_W-1:0] P_RST = ADDR_W'(P_WORD_RST);

   state_t                     state_q, state_d;
   logic [ACC_W-1:0]           acc_q, f_base_q, f_cur_q, f_cur_d;
   logic [ADDR_W-1:0]          p_word_q, phase_q;
   logic [WSEL_W-1:0]          wave_sel_q;
   logic                       wrap_q, pending_q;
   logic [WSEL_W+ADDR_W-1:0]   rom_addr_q;
   logic [DATA_W-1:0]          dac_q, dac_d;
   logic [3:0]                 vld_pipe_q;
   logic [ACC_W-1:0]           sh_f_q;
   logic [ADDR_W-1:0]          sh_p_q;
   logic [WSEL_W-1:0]          sh_ws_q;
   logic [ACC_W:0]             acc_sum, up_sum, dn_lim;
   logic                       apply, degen;

   assign acc_sum = {1'b0, acc_q} + {1'b0, f_cur_q};
   assign up_sum  = {1'b0, f_cur_q} + {1'b0, sweep_step};
   assign dn_lim  = {1'b0, f_base_q} + {1'b0, sweep_step};
   // A sweep range that is empty or has no step pins f_cur to f_base.
   assign degen   = (sweep_f_max <= f_base_q) | (sweep_step == '0);
   // Pending config lands immediately when idle, otherwise only on a wrap.
   assign apply   = pending_q & ((state_q == S_IDLE) | wrap_q);

`ifdef AMP_SCALE_EN
   logic [7:0]          amp_q, sh_amp_q;
   logic [DATA_W+8:0]   prod;
   assign prod  = (DATA_W+9)'(rom_q) * (DATA_W+9)'({1'b0, amp_q} + 9'd1);
   assign dac_d = prod[DATA_W+7:8];
`else
   assign dac_d = rom_q;
`endif

   // Next state and next frequency word; a config apply overrides sweep steps.
   always_comb begin
      state_d = state_q;
      f_cur_d = f_cur_q;
      if (!run) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = sweep_en ? S_UP : S_RUN;
               f_cur_d = f_base_q;
            end
            // RUN is only ever entered with sweep_en low, so level == rising edge.
            S_RUN: if (sweep_en) begin
               state_d = S_UP;
               f_cur_d = f_base_q;
            end
            S_UP, S_DOWN: begin
               if (!sweep_en) begin
                  state_d = S_RUN;
                  f_cur_d = f_base_q;
               end else if (wrap_q) begin
                  if (state_q == S_UP) begin
                     if (degen) begin
                        f_cur_d = f_base_q;
                     end else if (up_sum >= {1'b0, sweep_f_max}) begin
                        f_cur_d = sweep_f_max;
                        state_d = S_DOWN;
                     end else begin
                        f_cur_d = up_sum[ACC_W-1:0];
                     end
                  end else begin
                     if ({1'b0, f_cur_q} <= dn_lim) begin
                        f_cur_d = f_base_q;
                        state_d = S_UP;
                     end else begin
                        f_cur_d = f_cur_q - sweep_step;
                     end
                  end
               end
            end
         endcase
      end
      if (apply) begin
         f_cur_d = sh_f_q;
         if (state_d == S_DOWN) state_d = S_UP;
      end
   end

   // Control registers: FSM, frequency words, config shadow and apply.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         f_cur_q    <= F_RST;
         f_base_q   <= F_RST;
         p_word_q   <= P_RST;
         wave_sel_q <= '0;
         pending_q  <= 1'b0;
         sh_f_q     <= F_RST;
         sh_p_q     <= P_RST;
         sh_ws_q    <= '0;
`ifdef AMP_SCALE_EN
         amp_q      <= 8'd255;
         sh_amp_q   <= 8'd255;
`endif
      end else begin
         state_q <= state_d;
         f_cur_q <= f_cur_d;
         if (apply) begin
            f_base_q   <= sh_f_q;
            p_word_q   <= sh_p_q;
            wave_sel_q <= sh_ws_q;
`ifdef AMP_SCALE_EN
            amp_q      <= sh_amp_q;
`endif
            pending_q  <= 1'b0;
         end else if (cfg_valid && !pending_q) begin
            sh_f_q    <= cfg_f_word;
            sh_p_q    <= cfg_p_word;
            sh_ws_q   <= (int'(cfg_wave_sel) >= N_WAVE) ? '0 : cfg_wave_sel;
`ifdef AMP_SCALE_EN
            sh_amp_q  <= cfg_amp;
`endif
            pending_q <= 1'b1;
         end
      end
   end

   // Datapath pipeline; the accumulator holds while idle so the held sample repeats.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         acc_q      <= '0;
         wrap_q     <= 1'b0;
         phase_q    <= '0;
         rom_addr_q <= '0;
         dac_q      <= '0;
         vld_pipe_q <= '0;
      end else begin
         if (state_q != S_IDLE) begin
            acc_q  <= acc_sum[ACC_W-1:0];
            wrap_q <= acc_sum[ACC_W];
         end else begin
            wrap_q <= 1'b0;
         end
         phase_q    <= acc_q[ACC_W-1 -: ADDR_W] + p_word_q;
         rom_addr_q <= {wave_sel_q, phase_q};
         dac_q      <= dac_d;
         vld_pipe_q <= {vld_pipe_q[2:0], run};
      end
   end

   assign cfg_ready = ~pending_q;
   assign rom_addr  = rom_addr_q;
   assign dac_data  = dac_q;
   assign dac_valid = vld_pipe_q[3];
   assign wrap      = wrap_q;
   assign state     = state_q;

endmodule

// File: tb/tb_dds_gen_multi.sv
// Bench for dds_gen_multi: directed phases then random traffic, every output
// compared each clock against a behavioural model of the generator.
module tb_dds_gen_multi;
   localparam int ACC_W = 32, ADDR_W = 12, N_WAVE = 3, WSEL_W = 2, DATA_W = 8;

   logic        sys_clk = 1'b0, sys_rst_n = 1'b1, run = 1'b0, cfg_valid = 1'b0;
   logic        cfg_ready, sweep_en = 1'b0, dac_valid, wrap;
   logic [31:0] cfg_f_word = '0, sweep_step = '0, sweep_f_max = '0;
   logic [11:0] cfg_p_word = '0;
   logic [1:0]  cfg_wave_sel = '0, state;
   logic [13:0] rom_addr;
   logic [7:0]  rom_q = '0, dac_data;
`ifdef AMP_SCALE_EN
   logic [7:0]  cfg_amp = 8'd255;
`endif

   int tests = 0, fails = 0;

   dds_gen_multi #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .N_WAVE(N_WAVE),
                   .WSEL_W(WSEL_W), .DATA_W(DATA_W)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run(run),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_f_word(cfg_f_word),
      .cfg_p_word(cfg_p_word), .cfg_wave_sel(cfg_wave_sel),
`ifdef AMP_SCALE_EN
      .cfg_amp(cfg_amp),
`endif
      .sweep_en(sweep_en), .sweep_step(sweep_step), .sweep_f_max(sweep_f_max),
      .rom_addr(rom_addr), .rom_q(rom_q), .dac_data(dac_data),
      .dac_valid(dac_valid), .wrap(wrap), .state(state));

   always #5 sys_clk = ~sys_clk;

   function automatic logic [7:0] rom_fn(input logic [13:0] a);
      return a[7:0] ^ a[13:6];
   endfunction

   // external synchronous ROM, 1-cycle latency
   always @(posedge sys_clk) rom_q <= rom_fn(rom_addr);

   // ---- behavioural model (0 idle, 1 run, 2 sweep up, 3 sweep down) ----
   logic [31:0] m_acc, m_fbase, m_fcur, m_sf;
   logic [11:0] m_p, m_sp, m_phase;
   logic [1:0]  m_ws, m_sw;
   logic [13:0] m_addr;
   logic [7:0]  m_romq, m_dac, m_amp, m_samp;
   logic [3:0]  m_vld;
   int          m_state;
   bit          m_pend, m_wrap, m_sw_prev;

   task automatic model_reset();
      m_acc = 0; m_fbase = 42949; m_fcur = 42949; m_sf = 42949;
      m_p = 1024; m_sp = 1024; m_phase = 0; m_ws = 0; m_sw = 0;
      m_addr = 0; m_dac = 0; m_vld = 0; m_state = 0;
      m_pend = 0; m_wrap = 0; m_sw_prev = 0; m_amp = 255; m_samp = 255;
   endtask

   task automatic tick();
      longint      s, up;
      logic [31:0] nacc, nf;
      logic [11:0] nph;
      logic [13:0] nad;
      logic [7:0]  ndac, nrq;
      int          ns;
      bit          nwrap, ap;
      nph = 12'((m_acc >> (ACC_W - ADDR_W)) + 32'(m_p));
      nad = 14'(int'(m_ws) * 4096 + int'(m_phase));
`ifdef AMP_SCALE_EN
      ndac = 8'((int'(m_romq) * (int'(m_amp) + 1)) / 256);
`else
      ndac = m_romq;
`endif
      nrq = rom_fn(m_addr);
      nacc = m_acc; nwrap = 0;
      if (m_state != 0) begin
         s = longint'(m_acc) + longint'(m_fcur);
         nwrap = (s >= 64'h1_0000_0000);
         nacc = 32'(s % 64'h1_0000_0000);
      end
      ns = m_state; nf = m_fcur;
      if (!run) ns = 0;
      else if (m_state == 0) begin ns = sweep_en ? 2 : 1; nf = m_fbase; end
      else if (m_state == 1) begin
         if (sweep_en && !m_sw_prev) begin ns = 2; nf = m_fbase; end
      end else if (!sweep_en) begin ns = 1; nf = m_fbase; end
      else if (m_wrap) begin
         if (m_state == 2) begin
            up = longint'(m_fcur) + longint'(sweep_step);
            if (sweep_f_max <= m_fbase || sweep_step == 0) nf = m_fbase;
            else if (up >= longint'(sweep_f_max)) begin nf = sweep_f_max; ns = 3; end
            else nf = 32'(up);
         end else begin
            if (longint'(m_fcur) <= longint'(m_fbase) + longint'(sweep_step)) begin
               nf = m_fbase; ns = 2;
            end else nf = m_fcur - sweep_step;
         end
      end
      ap = m_pend && (m_state == 0 || m_wrap);
      if (ap) begin
         m_fbase = m_sf; nf = m_sf; m_p = m_sp; m_ws = m_sw; m_amp = m_samp;
         if (ns == 3) ns = 2;
         m_pend = 0;
      end else if (cfg_valid && !m_pend) begin
         m_sf = cfg_f_word; m_sp = cfg_p_word;
         m_sw = (int'(cfg_wave_sel) >= N_WAVE) ? 2'd0 : cfg_wave_sel;
`ifdef AMP_SCALE_EN
         m_samp = cfg_amp;
`endif
         m_pend = 1;
      end
      m_sw_prev = sweep_en;
      m_vld = {m_vld[2:0], run};
      m_acc = nacc; m_wrap = nwrap; m_fcur = nf; m_state = ns;
      m_phase = nph; m_addr = nad; m_romq = nrq; m_dac = ndac;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("dac_data", 32'(dac_data), 32'(m_dac));
      chk("dac_valid", 32'(dac_valid), 32'(m_vld[3]));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("state", 32'(state), 32'(m_state));
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge sys_clk);
         tick();
         @(negedge sys_clk);
         check_all();
      end
   endtask

   task automatic offer(input logic [31:0] f, input logic [11:0] p, input logic [1:0] w);
      cfg_valid = 1'b1; cfg_f_word = f; cfg_p_word = p; cfg_wave_sel = w;
   endtask

   // mid-stream reset applied and released between clock edges
   task automatic mid_reset();
      sys_rst_n = 1'b0;
      model_reset();
      #1 check_all();
      #1 sys_rst_n = 1'b1;
   endtask

   initial begin
      int r;
      #1 sys_rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge sys_clk);
      m_romq = rom_fn(14'd0);
      check_all();
      sys_rst_n = 1'b1;

      // defaults: first phase 1024, slow advance, dac_valid 4 clocks after run
      cyc(2);
      run = 1'b1;
      cyc(60);

      // idle apply, then a coherent apply at the next wrap while running
      run = 1'b0; cyc(3);
      offer(32'h0800_0000, 12'h123, 2'd1); cyc(1);
      cfg_valid = 1'b0; cyc(2);
      run = 1'b1; cyc(10);
      offer(32'h8000_0000, 12'h000, 2'd2); cyc(1);
      offer(32'h0400_0000, 12'h055, 2'd1); cyc(40);   // second offer stalls until apply
      cfg_valid = 1'b0; cyc(10);

      // hold 10 clocks, then resume from the held phase
      run = 1'b0; cyc(10);
      run = 1'b1; cyc(20);

      // ping-pong sweep 2^28 .. 2^30 step 2^28
      offer(32'h1000_0000, 12'h000, 2'd0); cyc(1);
      cfg_valid = 1'b0; cyc(70);
      sweep_step = 32'h1000_0000; sweep_f_max = 32'h4000_0000; sweep_en = 1'b1;
      cyc(220);
      sweep_en = 1'b0; cyc(20);
      sweep_en = 1'b1; cyc(40);

      // out-of-range wave select and empty sweep range
      offer(32'h2000_0000, 12'h400, 2'd3); cyc(1);
      cfg_valid = 1'b0;
      sweep_f_max = 32'h1000_0000; cyc(120);
      sweep_step = 32'd0; sweep_f_max = 32'h8000_0000; cyc(60);

      // reset with a config pending
      offer(32'h0200_0000, 12'h777, 2'd2); cyc(1);
      cfg_valid = 1'b0; cyc(1);
      mid_reset();
      cyc(20);

      // random traffic
      sweep_step = 32'h0200_0000; sweep_f_max = 32'h3000_0000;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) run = ~run;
         if (r >= 3 && r < 6) sweep_en = ~sweep_en;
         cfg_valid   = (r >= 10 && r < 25);
         cfg_f_word  = $urandom_range(32'h0400_0000, 32'h4000_0000);
         cfg_p_word  = 12'($urandom);
         cfg_wave_sel = 2'($urandom);
`ifdef AMP_SCALE_EN
         cfg_amp     = 8'($urandom);
`endif
         if (r == 50) sweep_step = $urandom_range(32'h0100_0000, 32'h1000_0000);
         if (r == 51) sweep_f_max = $urandom_range(32'h0800_0000, 32'h8000_0000);
         if (r == 52) sweep_step = 32'd0;
         if (i == 700) begin
            run = 1'b1;
            mid_reset();
         end
         cyc(1);
      end
      cfg_valid = 1'b0;
      cyc(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
